// File: rtl/xlb_out_framer_if.sv
// HLS-to-Xillybus handshake bundle for xlb_out_framer.
// slave = framer side, master = HLS core plus Xillybus core side.
interface xlb_out_framer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] hls_din;
  logic              hls_write;
  logic              hls_full_n;
  logic              user_r_rden;
  logic              user_r_empty;
  logic [DATA_W-1:0] user_r_data;
  logic              user_r_eof;
  logic              user_r_open;

  modport slave (
    input  hls_din, hls_write, user_r_rden, user_r_open,
    output hls_full_n, user_r_empty, user_r_data, user_r_eof
  );

  modport master (
    output hls_din, hls_write, user_r_rden, user_r_open,
    input  hls_full_n, user_r_empty, user_r_data, user_r_eof
  );
endinterface

// File: rtl/xlb_out_framer.sv
// Buffers HLS output words onto a Xillybus read stream and raises EOF after frame_len words.
// Define XLB_OUT_FRAMER_STATS_EN to add the ovf_sticky / frame_cnt / max_fill outputs.
module xlb_out_framer #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 9,
  parameter int LEN_W      = 16
) (
  input  logic              bus_clk,
  input  logic              srst,
  input  logic [LEN_W-1:0]  frame_len,
  xlb_out_framer_if.slave   bus
`ifdef XLB_OUT_FRAMER_STATS_EN
  ,
  output logic              ovf_sticky,
  output logic [LEN_W-1:0]  frame_cnt,
  output logic [DEPTH_LOG2:0] max_fill
`endif
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [LEN_W-1:0]      len_q, len_d, rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0]     data_q, data_d;

  logic rst_eff, full_n, empty, eof, rd_acc, wr_acc, frame_done;

  assign rst_eff = srst || !bus.user_r_open;
  assign rd_acc  = bus.user_r_rden && !empty;
  assign wr_acc  = bus.hls_write && full_n;

  // FSM: state register
  always_ff @(posedge bus_clk) begin
    if (rst_eff) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state (reset priority lives in the register)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_STREAM;
      S_STREAM: if (rd_acc && (len_q != '0) && (rd_cnt_q + LEN_W'(1) == len_q))
                  state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    full_n = (count_q != FULL_CNT) && (state_q == S_STREAM);
    empty  = (count_q == '0) || (state_q != S_STREAM);
    eof    = (state_q == S_DONE);
  end

  assign frame_done       = (state_q == S_STREAM) && (state_d == S_DONE);
  assign bus.hls_full_n   = full_n;
  assign bus.user_r_empty = empty;
  assign bus.user_r_eof   = eof;
  assign bus.user_r_data  = data_q;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    data_d   = data_q;
    if (state_q == S_IDLE) begin
      len_d    = frame_len;
      rd_cnt_d = '0;
    end
    if (rd_acc) begin
      data_d = mem_q[rptr_q];
      rptr_d = rptr_q + 1'b1;
      // Only unlimited frames can reach the top; bounded ones stop at len_q.
      if (!((len_q == '0) && (rd_cnt_q == '1))) rd_cnt_d = rd_cnt_q + 1'b1;
    end
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (rst_eff) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      len_q    <= '0;
      rd_cnt_q <= '0;
      data_q   <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      len_q    <= len_d;
      rd_cnt_q <= rd_cnt_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (wr_acc && !rst_eff) mem_q[wptr_q] <= bus.hls_din;
  end

`ifdef XLB_OUT_FRAMER_STATS_EN
  logic              ovf_q;
  logic [LEN_W-1:0]  frame_cnt_q;
  logic [CW-1:0]     max_fill_q;

  always_ff @(posedge bus_clk) begin
    if (rst_eff) begin
      ovf_q      <= 1'b0;
      max_fill_q <= '0;
    end else begin
      if (bus.hls_write && !full_n && (state_q == S_STREAM)) ovf_q <= 1'b1;
      if (count_d > max_fill_q) max_fill_q <= count_d;
    end
  end

  // frame_cnt spans close/reopen, so only srst clears it.
  always_ff @(posedge bus_clk) begin
    if (srst)                        frame_cnt_q <= '0;
    else if (frame_done && !rst_eff) frame_cnt_q <= frame_cnt_q + 1'b1;
  end

  assign ovf_sticky = ovf_q;
  assign frame_cnt  = frame_cnt_q;
  assign max_fill   = max_fill_q;
`endif

endmodule

// File: tb/tb_xlb_out_framer.sv
// Self-checking bench for xlb_out_framer: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based frame model.
module tb_xlb_out_framer;

  localparam int DATA_W = 32;
  localparam int DEPTH_LOG2 = 9;
  localparam int LEN_W = 16;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic             bus_clk = 1'b0;
  logic             srst;
  logic [LEN_W-1:0] frame_len;

  xlb_out_framer_if #(.DATA_W(DATA_W)) bus ();

`ifdef XLB_OUT_FRAMER_STATS_EN
  logic               ovf_sticky;
  logic [LEN_W-1:0]   frame_cnt;
  logic [DEPTH_LOG2:0] max_fill;
`endif

  xlb_out_framer #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .LEN_W(LEN_W)) dut (
    .bus_clk   (bus_clk),
    .srst      (srst),
    .frame_len (frame_len),
    .bus       (bus.slave)
`ifdef XLB_OUT_FRAMER_STATS_EN
    ,
    .ovf_sticky(ovf_sticky),
    .frame_cnt (frame_cnt),
    .max_fill  (max_fill)
`endif
  );

  always #5 bus_clk = ~bus_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a frame is "waiting" for one cycle after open, then
  // streams until len words have been handed to the host.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_data;
  bit m_wait, m_done, m_ovf;
  int m_len, m_delivered, m_frames, m_max;

  function automatic bit m_stream();
    return !m_wait && !m_done;
  endfunction

  task automatic model_edge();
    bit stream, full_n, empty, rd, wr;
    stream = m_stream();
    full_n = stream && (mq.size() < DEPTH);
    empty  = !stream || (mq.size() == 0);
    if (srst || !bus.user_r_open) begin
      mq.delete();
      m_wait = 1; m_done = 0; m_ovf = 0; m_data = '0;
      m_delivered = 0; m_max = 0;
      if (srst) m_frames = 0;
    end else if (m_wait) begin
      m_wait = 0;
      m_len = int'(frame_len);
      m_delivered = 0;
    end else if (stream) begin
      rd = bus.user_r_rden && !empty;
      wr = bus.hls_write && full_n;
      if (bus.hls_write && !full_n) m_ovf = 1;
      if (rd) begin
        m_data = mq.pop_front();
        m_delivered++;
        if (m_len != 0 && m_delivered == m_len) begin
          m_done = 1;
          m_frames++;
        end
      end
      if (wr) mq.push_back(bus.hls_din);
      if (mq.size() > m_max) m_max = mq.size();
    end
  endtask

  task automatic check_outputs(string tag);
    logic exp_empty, exp_full_n, exp_eof;
    exp_empty  = !m_stream() || (mq.size() == 0);
    exp_full_n = m_stream() && (mq.size() < DEPTH);
    exp_eof    = m_done;
    vectors++;
    assert (bus.user_r_data === m_data) else begin
      miscompares++;
      $error("FAIL %s data: got %h expected %h", tag, bus.user_r_data, m_data);
    end
    vectors++;
    assert (bus.user_r_empty === exp_empty) else begin
      miscompares++;
      $error("FAIL %s empty: got %b expected %b", tag, bus.user_r_empty, exp_empty);
    end
    vectors++;
    assert (bus.user_r_eof === exp_eof) else begin
      miscompares++;
      $error("FAIL %s eof: got %b expected %b", tag, bus.user_r_eof, exp_eof);
    end
    vectors++;
    assert (bus.hls_full_n === exp_full_n) else begin
      miscompares++;
      $error("FAIL %s full_n: got %b expected %b", tag, bus.hls_full_n, exp_full_n);
    end
`ifdef XLB_OUT_FRAMER_STATS_EN
    vectors++;
    assert (ovf_sticky === m_ovf) else begin
      miscompares++;
      $error("FAIL %s ovf_sticky: got %b expected %b", tag, ovf_sticky, m_ovf);
    end
    vectors++;
    assert (int'(frame_cnt) == m_frames) else begin
      miscompares++;
      $error("FAIL %s frame_cnt: got %0d expected %0d", tag, frame_cnt, m_frames);
    end
    vectors++;
    assert (int'(max_fill) == m_max) else begin
      miscompares++;
      $error("FAIL %s max_fill: got %0d expected %0d", tag, max_fill, m_max);
    end
`endif
  endtask

  task automatic cycle(string tag);
    @(posedge bus_clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(bit s, bit op, bit wr, logic [DATA_W-1:0] din, bit rd);
    srst = s;
    bus.user_r_open = op;
    bus.hls_write = wr;
    bus.hls_din = din;
    bus.user_r_rden = rd;
  endtask

  task automatic reopen(int len);
    drive(0, 0, 0, '0, 0);
    cycle("close");
    frame_len = LEN_W'(len);
    drive(0, 1, 0, '0, 0);
    cycle("open");
  endtask

  initial begin
    frame_len = '0;
    drive(1, 0, 0, '0, 0);

    // 1: reset, then closed with HLS writes that must be ignored
    for (int i = 0; i < 3; i++) cycle("reset");
    vectors++;
    assert (bus.user_r_empty === 1'b1 && bus.user_r_eof === 1'b0 && bus.hls_full_n === 1'b0
            && bus.user_r_data === '0) else begin
      miscompares++;
      $error("FAIL reset_vals: got empty=%b eof=%b full_n=%b data=%h required 1 0 0 0",
             bus.user_r_empty, bus.user_r_eof, bus.hls_full_n, bus.user_r_data);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, DATA_W'($urandom), 0);
      cycle("closed_wr");
    end

    // 2: basic 4-word frame, fifth word stays buffered
    reopen(4);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, DATA_W'(32'h10 + i), 0);
      cycle("basic_wr");
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, '0, 1);
      cycle("basic_rd");
    end
    vectors++;
    assert (bus.user_r_eof === 1'b1 && bus.user_r_empty === 1'b1 && bus.hls_full_n === 1'b0
            && bus.user_r_data === 32'h13) else begin
      miscompares++;
      $error("FAIL basic_end: got eof=%b empty=%b full_n=%b data=%h required 1 1 0 00000013",
             bus.user_r_eof, bus.user_r_empty, bus.hls_full_n, bus.user_r_data);
    end

    // 3: fill to 512 with 600 write attempts, then drain in order
    reopen(0);
    for (int i = 0; i < 600; i++) begin
      drive(0, 1, 1, DATA_W'(i), 0);
      cycle("full_wr");
    end
    vectors++;
    assert (bus.hls_full_n === 1'b0) else begin
      miscompares++;
      $error("FAIL full_flag: got full_n=%b required 0", bus.hls_full_n);
    end
    for (int i = 0; i < 513; i++) begin
      drive(0, 1, 0, '0, 1);
      cycle("full_rd");
    end
    vectors++;
    assert (bus.user_r_data === DATA_W'(511) && bus.user_r_eof === 1'b0) else begin
      miscompares++;
      $error("FAIL drain_last: got data=%h eof=%b required 000001ff 0",
             bus.user_r_data, bus.user_r_eof);
    end

    // 4: steady write+read at count 1 across pointer wrap
    reopen(0);
    drive(0, 1, 1, 32'h1000, 0);
    cycle("pp_prime");
    for (int i = 1; i <= 1000; i++) begin
      drive(0, 1, 1, DATA_W'(32'h1000 + i), 1);
      cycle("pingpong");
    end

    // 5: close mid-frame, reopen with a short frame
    reopen(8);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, DATA_W'(32'h50 + i), 0);
      cycle("mid_wr");
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, '0, 1);
      cycle("mid_rd");
    end
    reopen(2);
    drive(0, 1, 1, 32'hA, 0); cycle("re_wr");
    drive(0, 1, 1, 32'hB, 0); cycle("re_wr");
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, '0, 1);
      cycle("re_rd");
    end
    vectors++;
    assert (bus.user_r_data === 32'hB && bus.user_r_eof === 1'b1) else begin
      miscompares++;
      $error("FAIL reopen_end: got data=%h eof=%b required 0000000b 1",
             bus.user_r_data, bus.user_r_eof);
    end

    // 6: rden while empty, then an exact-length frame
    reopen(3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, '0, 1);
      cycle("empty_rd");
    end
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, (i < 5), DATA_W'($urandom), ($urandom_range(0, 1) == 1));
      cycle("exact_len");
    end

    // random traffic with occasional close and srst
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) frame_len = LEN_W'($urandom_range(0, 12));
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) != 0),
            ($urandom_range(0, 2) != 0), DATA_W'($urandom), ($urandom_range(0, 1) == 1));
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
